// File: rtl/trng_rnd_collector_pkg.sv
// Shared constants for the TRNG entropy collector: word width, period width,
// bit-count width and the collector state encoding.
package trng_rnd_collector_pkg;

   localparam int DATA_W    = 16;
   localparam int CNT_W     = 32;
   localparam int BIT_CNT_W = 5;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SAMPLE = 2'd1;
   localparam logic [1:0] STALL  = 2'd2;

   // A zero period would never reach the sample point, so it runs as 1.
   function automatic logic [CNT_W-1:0] period_of(input logic [CNT_W-1:0] cnt);
      return (cnt == '0) ? CNT_W'(1) : cnt;
   endfunction

endpackage

// File: rtl/trng_rnd_collector_if.sv
// Collector-to-CRNGT word handshake: holding word, valid, read strobe and
// fill status. master = collector, slave = CRNGT consumer.
interface trng_rnd_collector_if;
   import trng_rnd_collector_pkg::*;

   logic                 crngt_collector_rd;
   logic [DATA_W-1:0]    collector_crngt_data;
   logic                 collector_valid;
   logic                 collector_stall;
   logic [BIT_CNT_W-1:0] bit_cnt;

   modport master (
      input  crngt_collector_rd,
      output collector_crngt_data,
      output collector_valid,
      output collector_stall,
      output bit_cnt
   );

   modport slave (
      output crngt_collector_rd,
      input  collector_crngt_data,
      input  collector_valid,
      input  collector_stall,
      input  bit_cnt
   );

endinterface

// File: rtl/trng_rnd_collector_vn.sv
// Von Neumann corrector (built only with TRNG_VN_CORRECTOR_EN): pairs raw
// samples, 01 -> 0, 10 -> 1, 00/11 dropped.
module trng_vn_corrector (
   input  logic rng_clk,
   input  logic rst,
   input  logic clr,
   input  logic smp_vld,
   input  logic smp_bit,
   output logic acc_vld,
   output logic acc_bit
);

   logic half_q, half_d;
   logic first_q, first_d;

   always_comb begin
      half_d  = half_q;
      first_d = first_q;
      acc_vld = 1'b0;
      acc_bit = first_q;
      if (clr) begin
         half_d  = 1'b0;
         first_d = 1'b0;
      end else if (smp_vld) begin
         if (!half_q) begin
            half_d  = 1'b1;
            first_d = smp_bit;
         end else begin
            half_d  = 1'b0;
            // the first bit of a differing pair is the output bit
            acc_vld = first_q ^ smp_bit;
         end
      end
   end

   always_ff @(posedge rng_clk) begin
      if (rst) begin
         half_q  <= 1'b0;
         first_q <= 1'b0;
      end else begin
         half_q  <= half_d;
         first_q <= first_d;
      end
   end

endmodule

// File: rtl/trng_rnd_collector.sv
// Entropy collector: samples rnd_bit every sample_cnt cycles into a 16-bit
// shift register, double-buffered behind a holding register read by the CRNGT.
// Optional von Neumann corrector on the sample path: TRNG_VN_CORRECTOR_EN.
//
//   state  | meaning
//   IDLE   | sampling disabled, period counter idle
//   SAMPLE | period counter running, bits shifted in on terminal count
//   STALL  | shift register full behind a full holding register, counter frozen
module trng_rnd_collector
   import trng_rnd_collector_pkg::*;
(
   input  logic                   rng_clk,
   input  logic                   rst,
   input  logic                   rnd_src_en,
   input  logic                   rnd_bit,
   input  logic [CNT_W-1:0]       sample_cnt,
   trng_rnd_collector_if.master   col
);

   logic [1:0]           state_q,  state_d;
   logic [CNT_W-1:0]     period_q, period_d;
   logic [CNT_W-1:0]     cnt_q,    cnt_d;
   logic [DATA_W-1:0]    shift_q,  shift_d;
   logic [BIT_CNT_W-1:0] bcnt_q,   bcnt_d;
   logic [DATA_W-1:0]    hold_q,   hold_d;
   logic                 valid_q,  valid_d;

   logic              smp_vld;
   logic              acc_vld;
   logic              acc_bit;
   logic [DATA_W-1:0] word;

   assign smp_vld = (state_q == SAMPLE) && rnd_src_en && (cnt_q == CNT_W'(1));

`ifdef TRNG_VN_CORRECTOR_EN
   trng_vn_corrector u_vn (
      .rng_clk (rng_clk),
      .rst     (rst),
      .clr     (state_q == IDLE),
      .smp_vld (smp_vld),
      .smp_bit (rnd_bit),
      .acc_vld (acc_vld),
      .acc_bit (acc_bit)
   );
`else
   assign acc_vld = smp_vld;
   assign acc_bit = rnd_bit;
`endif

   assign word = {shift_q[DATA_W-2:0], acc_bit};

   always_comb begin
      state_d  = state_q;
      period_d = period_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      bcnt_d   = bcnt_q;
      hold_d   = hold_q;
      valid_d  = valid_q;

      // a read of a pending word clears valid unless a new word lands below
      if (col.crngt_collector_rd && valid_q)
         valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (rnd_src_en) begin
               state_d  = SAMPLE;
               period_d = period_of(sample_cnt);
               cnt_d    = period_of(sample_cnt);
            end
         end

         SAMPLE: begin
            if (!rnd_src_en) begin
               state_d = IDLE;
               shift_d = '0;
               bcnt_d  = '0;
            end else begin
               if (cnt_q == CNT_W'(1))
                  cnt_d = period_q;
               else
                  cnt_d = cnt_q - CNT_W'(1);

               if (acc_vld) begin
                  shift_d = word;
                  if (bcnt_q == BIT_CNT_W'(DATA_W-1)) begin
                     if (!valid_q || col.crngt_collector_rd) begin
                        hold_d  = word;
                        valid_d = 1'b1;
                        bcnt_d  = '0;
                     end else begin
                        bcnt_d  = BIT_CNT_W'(DATA_W);
                        state_d = STALL;
                     end
                  end else begin
                     bcnt_d = bcnt_q + BIT_CNT_W'(1);
                  end
               end
            end
         end

         STALL: begin
            if (!rnd_src_en) begin
               state_d = IDLE;
               shift_d = '0;
               bcnt_d  = '0;
            end else if (col.crngt_collector_rd) begin
               hold_d  = shift_q;
               valid_d = 1'b1;
               bcnt_d  = '0;
               cnt_d   = period_q;
               state_d = SAMPLE;
            end
         end

         default: begin
            state_d = IDLE;
            shift_d = '0;
            bcnt_d  = '0;
         end
      endcase
   end

   always_ff @(posedge rng_clk) begin
      if (rst) begin
         state_q  <= IDLE;
         period_q <= '0;
         cnt_q    <= '0;
         shift_q  <= '0;
         bcnt_q   <= '0;
         hold_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         period_q <= period_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         bcnt_q   <= bcnt_d;
         hold_q   <= hold_d;
         valid_q  <= valid_d;
      end
   end

   assign col.collector_crngt_data = hold_q;
   assign col.collector_valid      = valid_q;
   assign col.collector_stall      = (state_q == STALL);
   assign col.bit_cnt              = bcnt_q;

endmodule

// File: tb/tb_trng_rnd_collector.sv
// Bench for trng_rnd_collector: queue-based reference model, word scoreboard
// popped by a separate monitor, directed scenarios plus a random run.
module tb_trng_rnd_collector;
   import trng_rnd_collector_pkg::*;

   logic             rng_clk = 1'b0;
   logic             rst = 1'b1;
   logic             rnd_src_en = 1'b0;
   logic             rnd_bit = 1'b0;
   logic [CNT_W-1:0] sample_cnt = '0;

   trng_rnd_collector_if bus ();

   trng_rnd_collector dut (
      .rng_clk    (rng_clk),
      .rst        (rst),
      .rnd_src_en (rnd_src_en),
      .rnd_bit    (rnd_bit),
      .sample_cnt (sample_cnt),
      .col        (bus)
   );

   always #5 rng_clk = ~rng_clk;

   int n_checks = 0;
   int n_errors = 0;

   // reference model: sampling view built from queues
   bit          m_active;
   int unsigned m_period;
   int unsigned m_wait;
   int unsigned m_nsamp;
   bit          m_bits[$];
   bit          m_pair[$];
   logic [15:0] m_hold;
   bit          m_valid;
   logic [15:0] exp_q[$];

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] pack_bits();
      logic [15:0] w;
      w = '0;
      foreach (m_bits[i]) w = {w[14:0], m_bits[i]};
      return w;
   endfunction

   task automatic model_reset();
      m_active = 0; m_period = 1; m_wait = 0; m_nsamp = 0;
      m_bits.delete(); m_pair.delete(); exp_q.delete();
      m_hold = '0; m_valid = 0;
   endtask

   task automatic model_step(input bit en, input bit b, input int unsigned sc, input bit rd);
      bit          loaded;
      bit          read_done;
      logic [15:0] w;
      loaded = 0;
      read_done = rd && m_valid;
      w = '0;
      if (!m_active) begin
         if (en) begin
            m_active = 1;
            m_period = (sc == 0) ? 1 : sc;
            m_wait = m_period;
         end
      end else if (!en) begin
         m_active = 0;
         m_bits.delete();
         m_pair.delete();
      end else if (m_bits.size() == 16) begin
         if (rd) begin
            w = pack_bits(); m_bits.delete(); m_wait = m_period; loaded = 1;
         end
      end else if (m_wait == 1) begin
         m_wait = m_period;
         m_nsamp++;
`ifdef TRNG_VN_CORRECTOR_EN
         m_pair.push_back(b);
         if (m_pair.size() == 2) begin
            if (m_pair[0] != m_pair[1]) m_bits.push_back(m_pair[0]);
            m_pair.delete();
         end
`else
         m_bits.push_back(b);
`endif
         if (m_bits.size() == 16 && (!m_valid || rd)) begin
            w = pack_bits(); m_bits.delete(); loaded = 1;
         end
      end else begin
         m_wait--;
      end
      if (loaded) begin
         m_hold = w; m_valid = 1; exp_q.push_back(w);
      end else if (read_done) begin
         m_valid = 0;
      end
   endtask

   task automatic compare_all();
      check("valid",   32'(bus.collector_valid),      32'(m_valid));
      check("data",    32'(bus.collector_crngt_data), 32'(m_hold));
      check("stall",   32'(bus.collector_stall),      32'(m_active && m_bits.size() == 16));
      check("bit_cnt", 32'(bus.bit_cnt),              32'(m_bits.size()));
   endtask

   task automatic step(input bit en, input bit b, input int unsigned sc, input bit rd);
      rnd_src_en = en; rnd_bit = b; sample_cnt = CNT_W'(sc); bus.crngt_collector_rd = rd;
      model_step(en, b, sc, rd);
      @(posedge rng_clk); #1;
      compare_all();
   endtask

   task automatic do_reset();
      rst = 1'b1; rnd_src_en = 1'b0; rnd_bit = 1'b0; bus.crngt_collector_rd = 1'b0;
      model_reset();
      @(posedge rng_clk); #1;
      rst = 1'b0;
      compare_all();
   endtask

   // monitor: a new word is presented when valid rises or survives a read
   bit pv = 0, pr = 0;
   always @(negedge rng_clk) begin
      if (rst) begin
         pv = 0; pr = 0;
      end else begin
         if (bus.collector_valid && (!pv || pr)) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL word_unexpected actual=%h required=none", bus.collector_crngt_data);
            end else begin
               check("word", 32'(bus.collector_crngt_data), 32'(exp_q.pop_front()));
            end
         end
         pv = bus.collector_valid;
         pr = bus.crngt_collector_rd;
      end
   end

   initial begin
      #1000000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int          n;
      bit          bad;
      logic [15:0] saved;
      logic [7:0]  vn_pat;
      bit          en, b, rd;

      do_reset();
      check("reset_valid", 32'(bus.collector_valid), 0);
      check("reset_data",  32'(bus.collector_crngt_data), 0);
      check("reset_bcnt",  32'(bus.bit_cnt), 0);

`ifndef TRNG_VN_CORRECTOR_EN
      // alternating bits at period 3
      n = 0;
      do begin step(1, (m_bits.size() % 2) == 0, 3, 0); n++; end
      while (!bus.collector_valid && n < 200);
      check("t1_latency", n, 49);
      check("t1_word", 32'(bus.collector_crngt_data), 16'hAAAA);

      // no reads: FFFF held, 0000 stalled behind it
      do_reset();
      n = 0;
      do begin step(1, m_nsamp < 16, 1, 0); n++; end
      while (m_bits.size() != 16 && n < 100);
      step(1, 0, 1, 0);
      check("t2_stall", 32'(bus.collector_stall), 1);
      check("t2_bcnt",  32'(bus.bit_cnt), 16);
      check("t2_data",  32'(bus.collector_crngt_data), 16'hFFFF);
      step(1, 0, 1, 1);
      check("t2_rd_data",  32'(bus.collector_crngt_data), 16'h0000);
      check("t2_rd_valid", 32'(bus.collector_valid), 1);
      check("t2_rd_stall", 32'(bus.collector_stall), 0);

      // read coinciding with the 16th sample of the next word
      bad = 0; n = 0;
      do begin
         rd = (m_bits.size() == 15) && (m_wait == 1);
         step(1, 1'($urandom), 1, rd);
         if (!bus.collector_valid || bus.collector_stall) bad = 1;
         n++;
      end while (!rd && n < 100);
      check("t3_valid_kept", 32'(bus.collector_valid), 1);
      check("t3_no_drop_stall", 32'(bad), 0);
      check("t3_bcnt", 32'(bus.bit_cnt), 0);

      // period 0 runs as 1; period change ignored until re-enable
      do_reset();
      n = 0;
      do begin step(1, 1, 0, 0); n++; end while (!bus.collector_valid && n < 50);
      check("t4_latency", n, 17);
      check("t4_word", 32'(bus.collector_crngt_data), 16'hFFFF);
      step(1, 1, 5, 1);
      n = 0;
      do begin step(1, 1, 5, 0); n++; end while (!bus.collector_valid && n < 200);
      check("t4_old_period", n, 15);
      step(0, 0, 5, 1);
      n = 0;
      do begin step(1, 1'($urandom), 5, 0); n++; end while (!bus.collector_valid && n < 200);
      check("t4_new_period", n, 81);

      // disable mid-word keeps the pending word; reset loses it
      do_reset();
      n = 0;
      do begin step(1, 1'($urandom), 2, 0); n++; end while (!bus.collector_valid && n < 100);
      saved = m_hold;
      n = 0;
      while (m_bits.size() != 7 && n < 100) begin step(1, 1'($urandom), 2, 0); n++; end
      check("t5_bcnt_before", 32'(bus.bit_cnt), 7);
      step(0, 0, 2, 0);
      check("t5_bcnt", 32'(bus.bit_cnt), 0);
      check("t5_valid", 32'(bus.collector_valid), 1);
      check("t5_data", 32'(bus.collector_crngt_data), 32'(saved));
      for (int i = 0; i < 4; i++) step(0, 1, 2, 0);
      check("t5_data_held", 32'(bus.collector_crngt_data), 32'(saved));
      do_reset();
      check("t5_rst_valid", 32'(bus.collector_valid), 0);
      check("t5_rst_data",  32'(bus.collector_crngt_data), 0);
`else
      // corrector: pairs 00,11,01,10 repeated give 0,1 per 8 samples
      vn_pat = 8'b00110110;
      n = 0;
      do begin step(1, vn_pat[7 - (m_nsamp % 8)], 1, 0); n++; end
      while (!bus.collector_valid && n < 200);
      check("t6_latency", n, 65);
      check("t6_word", 32'(bus.collector_crngt_data), 16'h5555);
`endif

      // random traffic against the model
      do_reset();
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            en = ($urandom_range(0, 24) != 0);
            b  = 1'($urandom);
            rd = ($urandom_range(0, 3) == 0);
            step(en, b, $urandom_range(0, 3), rd);
         end
      end

      bus.crngt_collector_rd = 1'b0;
      @(negedge rng_clk); #1;
      check("scoreboard_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
